mem_ctrl: RTL

- Memory controller between the CPU pipeline and the byte-wide RAM/IO bus.
- Arbitrates two requesters: instruction fetch (IF, read-only, 4 bytes) and the MEM stage (loads/stores of 1/2/4 bytes).
- Splits each access into sequential byte transfers and reassembles read data little-endian.
- Returns a one-cycle done pulse plus a busy indication that the MEM stage uses to back off.

---
 rtl/mem_ctrl_pkg.sv | 40 ++++
 rtl/mem_ctrl_if.sv | 40 ++++
 rtl/mem_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds the FSM encoding, data_len codes, bus widths and byte lane helpers.
package mem_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Loads carry the byte count, stores carry the byte count minus one.
  localparam logic [2:0] LEN_LB = 3'd1;
  localparam logic [2:0] LEN_LH = 3'd2;
  localparam logic [2:0] LEN_LW = 3'd4;
  localparam logic [2:0] LEN_SB = 3'd0;
  localparam logic [2:0] LEN_SH = 3'd1;
  localparam logic [2:0] LEN_SW = 3'd3;

  function automatic logic [BYTE_W-1:0] get_byte(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        idx);
    return w[idx*BYTE_W +: BYTE_W];
  endfunction

  function automatic logic [DATA_W-1:0] set_byte(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        idx,
                                                 input logic [BYTE_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = w;
    r[idx*BYTE_W +: BYTE_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side requester signals and byte-wide RAM/IO bus of the memory controller.
// slave is the controller view; master is the pipeline/RAM environment view.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              rdy_in;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [DATA_W-1:0] if_data;
  logic              read_mem;
  logic              write_mem;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        data_len;
  logic              mem_load_done;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        busy_state;
  logic [BYTE_W-1:0] ram_din;
  logic [BYTE_W-1:0] ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic              io_buffer_full;

  modport slave (
    input  rdy_in, if_req, if_addr, if_flush, read_mem, write_mem, mem_addr,
           mem_wdata, data_len, ram_din, io_buffer_full,
    output if_done, if_data, mem_load_done, mem_rdata, busy_state, ram_dout,
           ram_a, ram_wr
  );

  modport master (
    output rdy_in, if_req, if_addr, if_flush, read_mem, write_mem, mem_addr,
           mem_wdata, data_len, ram_din, io_buffer_full,
    input  if_done, if_data, mem_load_done, mem_rdata, busy_state, ram_dout,
           ram_a, ram_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM loads/stores onto a byte-serial RAM/IO bus, all outputs registered.
// Word read: 6 cycles accept-to-done; N-byte store: done in cycle N+1; requesters back off on busy_state.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  mem_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              is_if_q, is_if_d;
  logic              is_io_q, is_io_d;
  logic [1:0]        cool_q, cool_d;

  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [BYTE_W-1:0] ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              mem_done_q, mem_done_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [1:0]        busy_q, busy_d;

  logic              st_len_ok, ld_len_ok, io_addr, store_ok, load_ok, fetch_ok;
  logic [1:0]        rd_idx;

  assign st_len_ok = (bus.data_len == LEN_SB) || (bus.data_len == LEN_SH) ||
                     (bus.data_len == LEN_SW);
  assign ld_len_ok = (bus.data_len == LEN_LB) || (bus.data_len == LEN_LH) ||
                     (bus.data_len == LEN_LW);
  assign io_addr   = (bus.mem_addr >= IO_BASE);
  // The cooldown covers an IO FIFO that reports full a couple of cycles late.
  assign store_ok  = bus.write_mem && st_len_ok &&
                     !(io_addr && (bus.io_buffer_full || (cool_q != 2'd0)));
  assign load_ok   = bus.read_mem && ld_len_ok;
  assign fetch_ok  = bus.if_req && !bus.if_flush;

  // Byte k arrives two edges after its address was driven.
  assign rd_idx    = 2'(cnt_q - 3'd2);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdat_d      = wdat_q;
    asm_d       = asm_q;
    is_if_d     = is_if_q;
    is_io_d     = is_io_q;
    cool_d      = (cool_q != 2'd0) ? cool_q - 2'd1 : cool_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 2'b00;
        if (bus.rdy_in) begin
          if (store_ok) begin
            state_d    = ST_WRITE;
            len_d      = bus.data_len + 3'd1;
            base_d     = bus.mem_addr;
            wdat_d     = bus.mem_wdata;
            is_if_d    = 1'b0;
            is_io_d    = io_addr;
            cnt_d      = 3'd1;
            ram_a_d    = bus.mem_addr;
            ram_dout_d = get_byte(bus.mem_wdata, 2'd0);
            ram_wr_d   = 1'b1;
            busy_d     = 2'b01;
          end else if (load_ok) begin
            state_d = ST_READ;
            len_d   = bus.data_len;
            base_d  = bus.mem_addr;
            is_if_d = 1'b0;
            is_io_d = 1'b0;
            cnt_d   = 3'd1;
            asm_d   = '0;
            ram_a_d = bus.mem_addr;
            busy_d  = 2'b01;
          end else if (fetch_ok) begin
            state_d = ST_READ;
            len_d   = LEN_LW;
            base_d  = bus.if_addr;
            is_if_d = 1'b1;
            is_io_d = 1'b0;
            cnt_d   = 3'd1;
            asm_d   = '0;
            ram_a_d = bus.if_addr;
            busy_d  = 2'b10;
          end
        end
      end

      ST_READ: begin
        if (is_if_q && bus.if_flush) begin
          state_d = ST_IDLE;
          busy_d  = 2'b00;
        end else begin
          if (cnt_q < len_q) ram_a_d = base_q + ADDR_W'(cnt_q);
          if (cnt_q >= 3'd2) asm_d = set_byte(asm_q, rd_idx, bus.ram_din);
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == len_q + 3'd1) begin
            state_d = ST_DONE;
            if (is_if_q) begin
              if_done_d = 1'b1;
              if_data_d = asm_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = asm_d;
            end
          end
        end
      end

      ST_WRITE: begin
        if (cnt_q < len_q) begin
          ram_a_d    = base_q + ADDR_W'(cnt_q);
          ram_dout_d = get_byte(wdat_q, cnt_q[1:0]);
          ram_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d     = ST_DONE;
          mem_done_d  = 1'b1;
          mem_rdata_d = '0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 2'b00;
        if (is_io_q) cool_d = 2'd2;
        is_io_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdat_q      <= '0;
      asm_q       <= '0;
      is_if_q     <= 1'b0;
      is_io_q     <= 1'b0;
      cool_q      <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdat_q      <= wdat_d;
      asm_q       <= asm_d;
      is_if_q     <= is_if_d;
      is_io_q     <= is_io_d;
      cool_q      <= cool_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ram_a         = ram_a_q;
  assign bus.ram_dout      = ram_dout_q;
  assign bus.ram_wr        = ram_wr_q;
  assign bus.if_done       = if_done_q;
  assign bus.if_data       = if_data_q;
  assign bus.mem_load_done = mem_done_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.busy_state    = busy_q;

endmodule
